// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - opcodes, FSM states and instruction field positions for proc_core_mc
package proc_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_BEQZ = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hE;
  localparam logic [3:0] OP_OUT  = 4'hF;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RA_HI  = 11;
  localparam int RA_LO  = 9;
  localparam int RB_HI  = 8;
  localparam int RB_LO  = 6;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  localparam int NUM_REGS = 8;
  localparam int REG_AW   = 3;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_WB    = 2'd2,
    S_HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/proc_regfile.sv
// rtl/proc_regfile.sv - 8-entry register file, two async read ports, one sync write port
module proc_regfile
  import proc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];

endmodule

// File: rtl/proc_core_mc.sv
// rtl/proc_core_mc.sv - multi-cycle 16-bit-instruction core: FETCH/EXEC/WB/HALT gated by step
module proc_core_mc
  import proc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic [15:0]       instruction,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              halted
);

  state_t            state;
  logic [15:0]       ir;
  logic [DATA_W-1:0] res;
  logic              take_br;

  logic [3:0]        op;
  logic [REG_AW-1:0] ra;
  logic [REG_AW-1:0] rb;
  logic [7:0]        imm;
  logic [DATA_W-1:0] ra_val;
  logic [DATA_W-1:0] rb_val;
  logic              is_wr;
  logic              rf_we;

  assign op  = ir[OP_HI:OP_LO];
  assign ra  = ir[RA_HI:RA_LO];
  assign rb  = ir[RB_HI:RB_LO];
  assign imm = ir[IMM_HI:IMM_LO];

  assign is_wr = (op == OP_LDI) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI);
  assign rf_we = (state == S_WB) && step && is_wr;

  proc_regfile #(.DATA_W(DATA_W)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (ra),
    .ra_data (ra_val),
    .rb_addr (rb),
    .rb_data (rb_val),
    .we      (rf_we),
    .wa      (ra),
    .wd      (res)
  );

  // Single adder: LDI is 0 + zext(imm), SUB is a + ~b + 1.
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic              alu_sub;
  logic [DATA_W-1:0] alu_y;

  always_comb begin
    alu_a   = ra_val;
    alu_b   = rb_val;
    alu_sub = 1'b0;
    case (op)
      OP_LDI: begin
        alu_a = '0;
        alu_b = DATA_W'(imm);
      end
      OP_SUB:  alu_sub = 1'b1;
      OP_ADDI: alu_b = DATA_W'($signed(imm));
      default: ;
    endcase
    alu_y = alu_a + (alu_sub ? ~alu_b : alu_b) + DATA_W'(alu_sub);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      pc        <= '0;
      ir        <= '0;
      res       <= '0;
      take_br   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else if (step) begin
      case (state)
        S_FETCH: begin
          ir    <= instruction;
          state <= S_EXEC;
        end
        S_EXEC: begin
          res     <= alu_y;
          take_br <= (op == OP_JMP) || ((op == OP_BEQZ) && (ra_val == '0));
          if (op == OP_OUT) begin
            out_valid <= 1'b1;
            out_data  <= ra_val;
          end
          state <= S_WB;
        end
        S_WB: begin
          if (op == OP_HALT) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else if (op == OP_OUT) begin
            if (out_valid && out_ready) begin
              out_valid <= 1'b0;
              pc        <= pc + PC_W'(1);
              state     <= S_FETCH;
            end
          end else begin
            pc    <= take_br ? imm[PC_W-1:0] : pc + PC_W'(1);
            state <= S_FETCH;
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_core_mc.sv
// tb/tb_proc_core_mc.sv - self-checking bench for proc_core_mc
module tb_proc_core_mc;

  localparam logic [3:0] T_NOP  = 4'h0;
  localparam logic [3:0] T_LDI  = 4'h1;
  localparam logic [3:0] T_ADD  = 4'h2;
  localparam logic [3:0] T_SUB  = 4'h3;
  localparam logic [3:0] T_ADDI = 4'h4;
  localparam logic [3:0] T_BEQZ = 4'h5;
  localparam logic [3:0] T_JMP  = 4'h6;
  localparam logic [3:0] T_HALT = 4'hE;
  localparam logic [3:0] T_OUT  = 4'hF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] instruction;
  logic [2:0]  pc;
  logic [15:0] out_data;
  logic        out_valid;
  logic        halted;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];
  logic [15:0] rom[8];

  always #5 clk = ~clk;

  assign instruction = rom[pc];

  proc_core_mc #(.DATA_W(16), .PC_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .step        (step),
    .instruction (instruction),
    .pc          (pc),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .halted      (halted)
  );

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] ra,
                                      input logic [2:0] rb, input logic [7:0] imm);
    return {op, ra, 9'b0} | {7'b0, rb, 6'b0} | {8'b0, imm};
  endfunction

  // Scoreboard: every accepted output word is popped and compared.
  always @(negedge clk) begin
    if (rst_n && step && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got out_data=%h with no expected entry", out_data);
      end else begin
        logic [15:0] exp_w;
        exp_w = sb.pop_front();
        if (out_data !== exp_w) begin
          errors++;
          $display("FAIL sb_out_data: got %h expected %h", out_data, exp_w);
        end
      end
    end
  end

  task automatic fill_rom(input logic [15:0] w);
    for (int i = 0; i < 8; i++) rom[i] = w;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_halt(input string name, input int budget);
    int k;
    k = 0;
    while (!halted && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL %s_halt_timeout: halted=%b expected 1", name, halted);
    end
  endtask

  task automatic check_sb_empty(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_sb_pending: got %0d outstanding expected 0", name, sb.size());
    end
  endtask

  task automatic test_reset;
    fill_rom(enc(T_NOP, 0, 0, 0));
    step = 1'b1;
    out_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({pc, out_data, out_valid, halted} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got pc=%0d out_data=%h out_valid=%b halted=%b expected all 0",
               pc, out_data, out_valid, halted);
    end
    cycles(3);
    checks++;
    if (pc !== 3'd0) begin
      errors++;
      $display("FAIL reset_hold_pc: got %0d expected 0", pc);
    end
  endtask

  task automatic test_add_out;
    int first;
    int n_valid;
    fill_rom(enc(T_HALT, 0, 0, 0));
    rom[0] = enc(T_LDI, 1, 0, 8'd5);
    rom[1] = enc(T_LDI, 2, 0, 8'd7);
    rom[2] = enc(T_ADD, 1, 2, 8'd0);
    rom[3] = enc(T_OUT, 1, 0, 8'd0);
    step = 1'b1;
    out_ready = 1'b1;
    sb.push_back(16'd12);
    apply_reset;
    first = 0;
    n_valid = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (out_valid) begin
        n_valid++;
        if (first == 0) first = k;
      end
    end
    checks++;
    if (first != 12) begin
      errors++;
      $display("FAIL add_out_latency: got first valid at cycle %0d expected 12", first);
    end
    checks++;
    if (n_valid != 1) begin
      errors++;
      $display("FAIL add_out_valid_len: got %0d cycles expected 1", n_valid);
    end
    checks++;
    if (pc !== 3'd4) begin
      errors++;
      $display("FAIL add_out_pc: got %0d expected 4", pc);
    end
    check_sb_empty("add_out");
  endtask

  task automatic test_arith;
    fill_rom(enc(T_HALT, 0, 0, 0));
    rom[0] = enc(T_LDI,  1, 0, 8'd1);
    rom[1] = enc(T_SUB,  0, 1, 8'd0);
    rom[2] = enc(T_OUT,  0, 0, 8'd0);
    rom[3] = enc(T_LDI,  2, 0, 8'hFF);
    rom[4] = enc(T_ADDI, 2, 0, 8'hFF);
    rom[5] = enc(T_OUT,  2, 0, 8'd0);
    step = 1'b1;
    out_ready = 1'b1;
    sb.push_back(16'hFFFF);
    sb.push_back(16'h00FE);
    apply_reset;
    wait_halt("arith", 60);
    checks++;
    if (pc !== 3'd6) begin
      errors++;
      $display("FAIL arith_halt_pc: got %0d expected 6", pc);
    end
    check_sb_empty("arith");
  endtask

  task automatic test_nop_wrap;
    fill_rom(enc(T_NOP, 0, 0, 0));
    step = 1'b1;
    apply_reset;
    for (int k = 1; k <= 8; k++) begin
      cycles(3);
      checks++;
      if (pc !== 3'(k)) begin
        errors++;
        $display("FAIL nop_pc_seq: got %0d expected %0d", pc, 3'(k));
      end
    end
    step = 1'b0;
    cycles(10);
    checks++;
    if (pc !== 3'd0) begin
      errors++;
      $display("FAIL nop_stall_pc: got %0d expected 0", pc);
    end
    step = 1'b1;
    cycles(1);
    rom[0] = enc(T_JMP, 0, 0, 8'd5);
    cycles(2);
    checks++;
    if (pc !== 3'd1) begin
      errors++;
      $display("FAIL nop_resume_pc: got %0d expected 1", pc);
    end
  endtask

  task automatic test_branch;
    logic [2:0] exp_pc[5];
    exp_pc = '{3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
    fill_rom(enc(T_HALT, 0, 0, 0));
    rom[0] = enc(T_BEQZ, 3, 0, 8'd6);
    rom[6] = enc(T_LDI,  3, 0, 8'd1);
    rom[7] = enc(T_BEQZ, 3, 0, 8'd6);
    rom[1] = enc(T_JMP,  0, 0, 8'h0A);
    step = 1'b1;
    apply_reset;
    for (int k = 0; k < 5; k++) begin
      cycles(3);
      checks++;
      if (pc !== exp_pc[k]) begin
        errors++;
        $display("FAIL branch_pc_%0d: got %0d expected %0d", k, pc, exp_pc[k]);
      end
    end
    cycles(3);
    checks++;
    if ({halted, pc} !== {1'b1, 3'd2}) begin
      errors++;
      $display("FAIL branch_halt: got halted=%b pc=%0d expected halted=1 pc=2", halted, pc);
    end
  endtask

  task automatic test_out_stall;
    fill_rom(enc(T_HALT, 0, 0, 0));
    rom[0] = enc(T_LDI, 4, 0, 8'h2D);
    rom[1] = enc(T_ADD, 4, 4, 8'd0);
    rom[2] = enc(T_OUT, 4, 0, 8'd0);
    step = 1'b1;
    out_ready = 1'b0;
    sb.push_back(16'h005A);
    apply_reset;
    cycles(8);
    for (int k = 0; k < 5; k++) begin
      cycles(1);
      checks++;
      if ({out_valid, out_data, pc} !== {1'b1, 16'h005A, 3'd2}) begin
        errors++;
        $display("FAIL stall_hold_%0d: got valid=%b data=%h pc=%0d expected valid=1 data=005a pc=2",
                 k, out_valid, out_data, pc);
      end
    end
    step = 1'b0;
    out_ready = 1'b1;
    cycles(2);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_step_low: got out_valid=%b expected 1", out_valid);
    end
    step = 1'b1;
    cycles(1);
    checks++;
    if ({out_valid, out_data, pc} !== {1'b0, 16'h005A, 3'd3}) begin
      errors++;
      $display("FAIL stall_release: got valid=%b data=%h pc=%0d expected valid=0 data=005a pc=3",
               out_valid, out_data, pc);
    end
    wait_halt("stall", 10);
    check_sb_empty("stall");
  endtask

  task automatic test_reset_exec_halt;
    fill_rom(enc(T_HALT, 0, 0, 0));
    rom[0] = enc(T_LDI, 1, 0, 8'd3);
    rom[1] = enc(T_ADD, 1, 1, 8'd0);
    rom[2] = enc(T_OUT, 1, 0, 8'd0);
    step = 1'b1;
    out_ready = 1'b1;
    apply_reset;
    cycles(4);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pc, out_data, out_valid, halted} !== 21'd0) begin
      errors++;
      $display("FAIL async_reset: got pc=%0d out_data=%h out_valid=%b halted=%b expected all 0",
               pc, out_data, out_valid, halted);
    end
    fill_rom(enc(T_HALT, 0, 0, 0));
    rom[0] = enc(T_OUT, 1, 0, 8'd0);
    sb.push_back(16'h0000);
    apply_reset;
    wait_halt("rst_halt", 20);
    check_sb_empty("rst_halt");
    for (int k = 0; k < 6; k++) begin
      step = ~step;
      cycles(1);
    end
    checks++;
    if ({halted, pc, out_valid} !== {1'b1, 3'd1, 1'b0}) begin
      errors++;
      $display("FAIL halt_absorb: got halted=%b pc=%0d valid=%b expected halted=1 pc=1 valid=0",
               halted, pc, out_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_add_out;
    test_arith;
    test_nop_wrap;
    test_branch;
    test_out_stall;
    test_reset_exec_halt;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
